sequence_checker: RTL
=====================

// Module: sequence_checker
// PURPOSE
//   Downstream consumer of the 3-bit LFSR sequence generator (serial output s3, period 7, 0011101...).
//   Self-synchronises to the serial stream using recurrence b[n] = b[n-1] ^ b[n-3].
//   After lock, predicts each incoming bit and flags mismatches; drops lock after repeated mismatches.
//   Marks one frame boundary per 7-bit period.
// PARAMETERS
//   CNT_W      8   width of err_count (and frame_count); must be >= 1
//   ERR_LIMIT  3   consecutive mismatches that drop lock; legal range 1..7
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   bit_in       in   1      serial bit from generator
//   bit_valid    in   1      bit_in consumed on a clk edge when 1; state holds when 0
//   err_clr      in   1      synchronous clear of err_count
//   locked       out  1      1 while in LOCK state
//   err_pulse    out  1      1-cycle pulse: consumed bit mismatched prediction
//   frame_pulse  out  1      1-cycle pulse: matched bit completed window 3'b001
//   stuck_zero   out  1      1 while in HUNT with 3 bits collected and window == 3'b000
//   err_count    out  CNT_W  saturating mismatch count
// BEHAVIOUR
// - Reset (async): state=HUNT, window w[2:0]=0, fill=0, consec=0, all outputs 0.
// - All outputs registered; they reflect the bit consumed at the preceding edge. Latency is 1 clk.
// - w[0] is the newest bit, w[2] the oldest. Each consumed bit shifts in: w <= {w[1:0], bit_in}, in every state.
// - Pulses (err_pulse, frame_pulse) are 0 on any edge with bit_valid=0.
// - HUNT
//   - Each consumed bit shifts in; fill increments, saturating at 3.
//   - When fill reaches 3 and the new window != 000: go to LOCK; locked=1 after that edge; consec=0.
//   - With no frame_pulse and no error check on that edge.
//   - If the window == 000 with fill==3: stay in HUNT; stuck_zero=1. The window is re-evaluated on every
//     later bit, and the block locks on the first nonzero window.
// - LOCK
//   - pred = w[0] ^ w[2], compared with bit_in.
//   - Match: consec=0. frame_pulse=1 if the post-shift window == 3'b001.
//   - Mismatch: err_pulse=1; err_count+1, saturating at 2^CNT_W-1; consec+1.
//     - If consec reaches ERR_LIMIT: go to HUNT, with fill=0, w=0, consec=0, locked=0 after the same edge.
//     - err_pulse is still asserted on that edge.
// - err_clr
//   - Clears err_count on the next edge.
//   - If a mismatch occurs on the same edge, err_count=1 (clear, then increment).
//   - Does not affect lock or consec.
// - frame_pulse fires once per 7 matched bits in a steady lock.
// - Reset mid-stream clears everything immediately, regardless of clk.
// CONFIGURATION
//   SEQCHK_FRAME_COUNT_EN defined:
//     - Adds port frame_count  out  CNT_W.
//     - Increments, wrapping, on each frame_pulse. Cleared only by reset.
//   SEQCHK_FRAME_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
// T1: reset, then 21 valid bits 0011101 x3 -> locked=1 after bit 3; err_count=0;
//     frame_pulse after bits 10 and 17 only.
// T2: as T1 but bit 12 inverted -> err_pulse after bits 12, 13, 15; err_count=3; locked stays 1 (ERR_LIMIT=3).
// T3: reset, then 6 zero bits -> stuck_zero=1 from bit 3; locked=0; then bits 1,1,1 -> locked=1, stuck_zero=0.
// T4: locked, then 3 bits each inverted from prediction -> err_pulse x3; locked=0 after the 3rd; err_count=3.
// T5: CNT_W=2, continuous inverted stream -> err_count saturates at 3; err_clr mid-stream -> err_count 0,
//     or 1 if a mismatch occurs on the same edge.
// T6: T1 stream with bit_valid toggling 1/0 each cycle, plus async reset asserted between edges at bit 9
//     -> identical results up to bit 9, then all outputs 0 immediately; relock after 3 more bits.
//     With SEQCHK_FRAME_COUNT_EN: frame_count=2 after T1.

Source files
------------

// File: rtl/sequence_checker.sv
// sequence_checker: self-synchronising checker for the 3-bit LFSR serial stream (b[n] = b[n-1] ^ b[n-3]), optional SEQCHK_FRAME_COUNT_EN adds frame_count
module sequence_checker #(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             frame_pulse,
  output logic             stuck_zero,
  output logic [CNT_W-1:0] err_count
`ifdef SEQCHK_FRAME_COUNT_EN
  ,
  output logic [CNT_W-1:0] frame_count
`endif
);
  localparam logic [2:0] LIM = 3'(ERR_LIMIT);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t state, state_nxt;
  logic [2:0] w, w_nxt, w_sh, consec, consec_nxt;
  logic [1:0] fill, fill_nxt, fill_up;
  logic mis, hit, drop, err_nxt, frame_nxt;
  logic [CNT_W-1:0] cnt_base, cnt_nxt;
  assign w_sh    = {w[1:0], bit_in};
  assign fill_up = fill == 2'd3 ? 2'd3 : fill + 2'd1;
  assign mis     = bit_valid && state == LOCK && (w[0] ^ w[2]) != bit_in;
  assign hit     = bit_valid && state == LOCK && !mis;
  assign drop    = mis && consec + 3'd1 == LIM;
  // state register and all registered datapath/outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= HUNT;
      w           <= '0;
      fill        <= '0;
      consec      <= '0;
      err_pulse   <= 1'b0;
      frame_pulse <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      w           <= w_nxt;
      fill        <= fill_nxt;
      consec      <= consec_nxt;
      err_pulse   <= err_nxt;
      frame_pulse <= frame_nxt;
      err_count   <= cnt_nxt;
    end
  // next state: lock on the first nonzero full window, drop after ERR_LIMIT consecutive mismatches
  always_comb begin
    state_nxt = state;
    if (bit_valid)
      state_nxt = state == HUNT ? ((fill_up == 2'd3 && w_sh != 3'b000) ? LOCK : HUNT)
                                : (drop ? HUNT : LOCK);
  end
  // next datapath values; a lock drop restarts the window from empty
  always_comb begin
    w_nxt      = !bit_valid ? w : drop ? 3'b000 : w_sh;
    fill_nxt   = !bit_valid ? fill : state == HUNT ? fill_up : drop ? 2'd0 : fill;
    consec_nxt = (drop || hit) ? 3'd0 : mis ? consec + 3'd1 : consec;
    err_nxt    = mis;
    frame_nxt  = hit && w_sh == 3'b001;
    cnt_base   = err_clr ? '0 : err_count;
    cnt_nxt    = (mis && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
  end
  // status outputs decoded from registered state
  always_comb begin
    locked     = state == LOCK;
    stuck_zero = state == HUNT && fill == 2'd3 && w == 3'b000;
  end
`ifdef SEQCHK_FRAME_COUNT_EN
  // wrapping count of frame boundaries
  always_ff @(posedge clk or posedge reset)
    if (reset) frame_count <= '0;
    else frame_count <= frame_count + CNT_W'(frame_nxt);
`endif
endmodule
